// File: rtl/pipelined_barrel_rotator_if.sv
// rtl/pipelined_barrel_rotator_if.sv - valid/ready bus for the pipelined barrel rotator
//
// Purpose: bundles the input and output handshakes of the rotator.
// Signals:
//   in_valid  - in_data/in_amt/in_lr are valid this cycle
//   in_ready  - rotator accepts input this cycle
//   in_data   - WIDTH-bit word to rotate
//   in_amt    - AMT_W-bit rotate amount
//   in_lr     - direction, 1 = left, 0 = right
//   out_valid - out_data holds a result
//   out_ready - downstream accepts the result this cycle
//   out_data  - rotated word
// Modports: master = traffic source/sink around the rotator, slave = the rotator.
interface pipelined_barrel_rotator_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_lr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_lr, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_lr, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipelined_barrel_rotator.sv
// rtl/pipelined_barrel_rotator.sv - AMT_W-stage pipelined left/right barrel rotator
//
// Purpose: rotates a WIDTH-bit word left (lr=1) or right (lr=0) by in_amt.
//   Stage k rotates by 2^k when amount bit k is set. Every stage is
//   registered; the whole pipeline advances or stalls together.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears all stage valids and data
//   bus   - pipelined_barrel_rotator_if.slave (in_* request, out_* result)
module pipelined_barrel_rotator #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  pipelined_barrel_rotator_if.slave     bus
);

  // Stage registers: data, full amount, direction and valid per stage.
  logic [WIDTH-1:0] data_q  [AMT_W];
  logic [AMT_W-1:0] amt_q   [AMT_W];
  logic [AMT_W-1:0] lr_q;
  logic [AMT_W-1:0] valid_q;

  // Stage inputs: stage 0 from the bus, stage k from stage k-1.
  logic [WIDTH-1:0] st_data [AMT_W];
  logic [AMT_W-1:0] st_amt  [AMT_W];
  logic [AMT_W-1:0] st_lr;
  logic [AMT_W-1:0] st_valid;

  logic adv;
  logic unused_tail;

  // Rotate d by 2^k. Truncating the source index to AMT_W bits is the
  // modulo-WIDTH wrap, since WIDTH is a power of two.
  function automatic logic [WIDTH-1:0] rotate_step(
    input logic [WIDTH-1:0] d,
    input logic             left,
    input int               k
  );
    logic [WIDTH-1:0] r;
    logic [AMT_W-1:0] src;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (left) src = AMT_W'(i - (1 << k));
      else      src = AMT_W'(i + (1 << k));
      r[i] = d[src];
    end
    return r;
  endfunction

  // Whole-pipeline advance: only a held result at the tail blocks movement.
  assign adv           = !valid_q[AMT_W-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[AMT_W-1];
  assign bus.out_data  = data_q[AMT_W-1];

  // The tail stage's direction and amount have no consumer.
  assign unused_tail = lr_q[AMT_W-1] ^ (^amt_q[AMT_W-1]);

  always_comb begin
    st_data[0]  = bus.in_data;
    st_amt[0]   = bus.in_amt;
    st_lr[0]    = bus.in_lr;
    st_valid[0] = bus.in_valid;
    for (int k = 1; k < AMT_W; k++) begin
      st_data[k]  = data_q[k-1];
      st_amt[k]   = amt_q[k-1];
      st_lr[k]    = lr_q[k-1];
      st_valid[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      lr_q    <= '0;
      for (int k = 0; k < AMT_W; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
      end
    end else if (adv) begin
      // Bubbles shift along with real words; their data is don't-care.
      for (int k = 0; k < AMT_W; k++) begin
        valid_q[k] <= st_valid[k];
        lr_q[k]    <= st_lr[k];
        amt_q[k]   <= st_amt[k];
        data_q[k]  <= st_amt[k][k] ? rotate_step(st_data[k], st_lr[k], k)
                                   : st_data[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// tb/tb_pipelined_barrel_rotator.sv - directed self-checking bench for pipelined_barrel_rotator
module tb_pipelined_barrel_rotator;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipelined_barrel_rotator_if #(.WIDTH(8), .AMT_W(3)) bus ();

  pipelined_barrel_rotator #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Interleaved stream vectors
  logic [7:0] s_data [4] = '{8'h01, 8'h01, 8'hF0, 8'h3C};
  logic [2:0] s_amt  [4] = '{3'd1, 3'd1, 3'd4, 3'd2};
  logic       s_lr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] s_exp  [4] = '{8'h02, 8'h80, 8'h0F, 8'h0F};
  logic [7:0] got_v  [$];
  int         got_t  [$];

  // Backpressure vectors
  logic [7:0] b_data [5] = '{8'h11, 8'h80, 8'h0F, 8'hAA, 8'h12};
  logic [2:0] b_amt  [5] = '{3'd1, 3'd7, 3'd2, 3'd3, 3'd4};
  logic       b_lr   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] b_exp  [5] = '{8'h22, 8'h40, 8'hC3, 8'h55, 8'h21};
  int i_in;
  int n_out;
  int stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic lr);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_lr    = lr;
  endtask

  task automatic run_single(input string tag, input logic [7:0] d, input logic [2:0] a,
                            input logic lr, input logic [7:0] exp);
    int lat;
    bus.out_ready = 1'b1;
    drive(1'b1, d, a, lr);
    #1;
    check({tag, " in_ready"}, bus.in_ready, 1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 3);
    check({tag, " data"}, bus.out_data, exp);
    tick();
    check({tag, " drained"}, bus.out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset in_ready", bus.in_ready, 1);
    reset = 1'b0;

    run_single("rotl 01 by 3", 8'h01, 3'd3, 1'b1, 8'h08);
    run_single("rotr 01 by 1", 8'h01, 3'd1, 1'b0, 8'h80);
    run_single("rotl 81 by 7", 8'h81, 3'd7, 1'b1, 8'hC0);
    run_single("pass A5 left", 8'hA5, 3'd0, 1'b1, 8'hA5);
    run_single("pass A5 right", 8'hA5, 3'd0, 1'b0, 8'hA5);
    run_single("rotr C3 by 5", 8'hC3, 3'd5, 1'b0, 8'h1E);

    // Back-to-back interleaved directions
    bus.out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 4) drive(1'b1, s_data[t], s_amt[t], s_lr[t]);
      else       drive(1'b0, 8'h00, 3'd0, 1'b0);
      #1;
      if (bus.out_valid) begin
        got_v.push_back(bus.out_data);
        got_t.push_back(t);
      end
      tick();
    end
    check("stream count", got_v.size(), 4);
    for (int j = 0; j < 4 && j < got_v.size(); j++) begin
      check($sformatf("stream word %0d", j), got_v[j], s_exp[j]);
      check($sformatf("stream gap %0d", j), got_t[j], got_t[0] + j);
    end
    if (got_t.size() > 0) check("stream first cycle", got_t[0], 3);

    // Backpressure: stall 5 cycles once the pipeline holds a result
    i_in  = 0;
    n_out = 0;
    stall = 0;
    for (int t = 0; t < 40 && n_out < 5; t++) begin
      bus.out_ready = (stall >= 5);
      if (i_in < 5) drive(1'b1, b_data[i_in], b_amt[i_in], b_lr[i_in]);
      else          drive(1'b0, 8'h00, 3'd0, 1'b0);
      #1;
      if (stall > 0 && stall < 5) begin
        check("bp hold valid", bus.out_valid, 1);
        check("bp hold data", bus.out_data, b_exp[0]);
        check("bp hold in_ready", bus.in_ready, 0);
        stall++;
      end else if (stall == 0 && bus.out_valid) begin
        check("bp first data", bus.out_data, b_exp[0]);
        check("bp first in_ready", bus.in_ready, 0);
        stall = 1;
      end
      if (bus.in_valid && bus.in_ready) i_in++;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp out %0d", n_out), bus.out_data, b_exp[n_out]);
        n_out++;
      end
      tick();
    end
    check("bp out count", n_out, 5);
    check("bp in count", i_in, 5);
    check("bp empty after", bus.out_valid, 0);

    // Reset while two words are in flight
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h01, 3'd1, 1'b1);
    tick();
    drive(1'b1, 8'h02, 3'd1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset out_data", bus.out_data, 0);
    run_single("post-reset rotl 04 by 2", 8'h04, 3'd2, 1'b1, 8'h10);
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("no ghost %0d", t), bus.out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
